// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared TAP state encodings, instruction codes and next-state function
package jtag_pkg;

    localparam int IR_W = 3;

    // Standard 1149.1 four-bit state encodings
    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_e;

    localparam logic [IR_W-1:0] INS_EXTEST = 3'b000;
    localparam logic [IR_W-1:0] INS_SAMPLE = 3'b001;
    localparam logic [IR_W-1:0] INS_INTEST = 3'b010;
    localparam logic [IR_W-1:0] INS_BYPASS = 3'b111;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        case (s)
            TLR:      n = tms ? TLR    : RTI;
            RTI:      n = tms ? SEL_DR : RTI;
            SEL_DR:   n = tms ? SEL_IR : CAP_DR;
            CAP_DR:   n = tms ? EX1_DR : SH_DR;
            SH_DR:    n = tms ? EX1_DR : SH_DR;
            EX1_DR:   n = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: n = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   n = tms ? UPD_DR : SH_DR;
            UPD_DR:   n = tms ? SEL_DR : RTI;
            SEL_IR:   n = tms ? TLR    : CAP_IR;
            CAP_IR:   n = tms ? EX1_IR : SH_IR;
            SH_IR:    n = tms ? EX1_IR : SH_IR;
            EX1_IR:   n = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: n = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   n = tms ? UPD_IR : SH_IR;
            UPD_IR:   n = tms ? SEL_DR : RTI;
            default:  n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state TAP controller state register
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tms,
    output tap_state_e state
);

    tap_state_e r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= TLR;
        end else begin
            r_state <= tap_next(r_state, tms);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/jtag_tap_ir.sv
// rtl/jtag_tap_ir.sv - TAP with instruction register, bypass bit, tdo mux and scan start pulses
module jtag_tap_ir
    import jtag_pkg::*;
#(
    parameter int IR_W = jtag_pkg::IR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tms,
    input  logic            tdi,
    input  logic            bsr_tdo,
    output logic            tdo,
    output logic [IR_W-1:0] ir_q,
    output logic            extest,
    output logic            intest,
    output logic            bypass_sel,
    output logic            capture_dr,
    output logic            shift_dr,
    output logic            update_dr,
    output logic [3:0]      tap_state
);

    localparam logic [IR_W-1:0] L_EXTEST  = IR_W'(INS_EXTEST);
    localparam logic [IR_W-1:0] L_SAMPLE  = IR_W'(INS_SAMPLE);
    localparam logic [IR_W-1:0] L_INTEST  = IR_W'(INS_INTEST);
    localparam logic [IR_W-1:0] L_BYPASS  = '1;
    localparam logic [IR_W-1:0] L_CAPTURE = IR_W'(2'b01);

    tap_state_e      w_state;
    logic [IR_W-1:0] w_ir_q;
    logic            w_bypass_sel;

    logic [IR_W-1:0] r_ir_shift;
    logic [IR_W-1:0] r_ir_q;
    logic            r_bypass;
    logic            r_tdo;
    logic            r_extest;
    logic            r_intest;

    jtag_tap_fsm u_fsm (
        .clk   (clk),
        .rst   (rst),
        .tms   (tms),
        .state (w_state)
    );

    // TLR overrides the held instruction immediately, not one cycle later
    assign w_ir_q       = (w_state == TLR) ? L_BYPASS : r_ir_q;
    assign w_bypass_sel = !((w_ir_q == L_EXTEST) || (w_ir_q == L_SAMPLE) || (w_ir_q == L_INTEST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ir_shift <= L_BYPASS;
            r_ir_q     <= L_BYPASS;
            r_bypass   <= 1'b0;
            r_tdo      <= 1'b0;
            r_extest   <= 1'b0;
            r_intest   <= 1'b0;
        end else begin
            r_extest <= 1'b0;
            r_intest <= 1'b0;
            case (w_state)
                TLR: begin
                    r_ir_q <= L_BYPASS;
                end
                CAP_IR: begin
                    r_ir_shift <= L_CAPTURE;
                end
                SH_IR: begin
                    r_ir_shift <= {tdi, r_ir_shift[IR_W-1:1]};
                    r_tdo      <= r_ir_shift[0];
                end
                UPD_IR: begin
                    r_ir_q   <= r_ir_shift;
                    r_extest <= (r_ir_shift == L_EXTEST);
                    r_intest <= (r_ir_shift == L_INTEST);
                end
                CAP_DR: begin
                    r_bypass <= 1'b0;
                end
                SH_DR: begin
                    r_bypass <= tdi;
                    r_tdo    <= w_bypass_sel ? r_bypass : bsr_tdo;
                end
                default: begin
                end
            endcase
        end
    end

    assign tdo        = r_tdo;
    assign ir_q       = w_ir_q;
    assign extest     = r_extest;
    assign intest     = r_intest;
    assign bypass_sel = w_bypass_sel;
    assign capture_dr = (w_state == CAP_DR);
    assign shift_dr   = (w_state == SH_DR);
    assign update_dr  = (w_state == UPD_DR);
    assign tap_state  = w_state;

endmodule

// File: tb/tb_jtag_tap_ir.sv
// tb/tb_jtag_tap_ir.sv - table-driven scoreboard bench for jtag_tap_ir
module tb_jtag_tap_ir;
    import jtag_pkg::*;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic       bsr;
        tap_state_e st;
        logic [2:0] ir;
        logic       ex;
        logic       ins;
        logic       tdo;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       tms;
    logic       tdi;
    logic       bsr_tdo;
    logic       tdo;
    logic [2:0] ir_q;
    logic       extest;
    logic       intest;
    logic       bypass_sel;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic [3:0] tap_state;

    int   n_assert;
    int   n_fail;
    vec_t vecs[$];
    vec_t exp_q[$];

    jtag_tap_ir #(.IR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .tms        (tms),
        .tdi        (tdi),
        .bsr_tdo    (bsr_tdo),
        .tdo        (tdo),
        .ir_q       (ir_q),
        .extest     (extest),
        .intest     (intest),
        .bypass_sel (bypass_sel),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .tap_state  (tap_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int row, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, row, got, exp);
        end
    endtask

    task automatic add(input int t, input int d, input int b, input tap_state_e st,
                       input int ir, input int ex, input int ins, input int o);
        vec_t v;
        v.tms = (t != 0);
        v.tdi = (d != 0);
        v.bsr = (b != 0);
        v.st  = st;
        v.ir  = 3'(ir);
        v.ex  = (ex != 0);
        v.ins = (ins != 0);
        v.tdo = (o != 0);
        vecs.push_back(v);
    endtask

    function automatic logic exp_bsel(input logic [2:0] ir);
        return !((ir == 3'b000) || (ir == 3'b001) || (ir == 3'b010));
    endfunction

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t e;
        n_assert = 0;
        n_fail   = 0;

        //  tms tdi bsr  state     ir ex in tdo
        add(0, 0, 0, RTI,      7, 0, 0, 0);
        // load EXTEST (000)
        add(1, 0, 0, SEL_DR,   7, 0, 0, 0);
        add(1, 0, 0, SEL_IR,   7, 0, 0, 0);
        add(0, 0, 0, CAP_IR,   7, 0, 0, 0);
        add(0, 0, 0, SH_IR,    7, 0, 0, 0);
        add(0, 0, 0, SH_IR,    7, 0, 0, 1);
        add(0, 0, 0, SH_IR,    7, 0, 0, 0);
        add(1, 0, 0, EX1_IR,   7, 0, 0, 0);
        add(1, 0, 0, UPD_IR,   7, 0, 0, 0);
        add(0, 0, 0, RTI,      0, 1, 0, 0);
        add(0, 0, 0, RTI,      0, 0, 0, 0);
        // load INTEST (010)
        add(1, 0, 0, SEL_DR,   0, 0, 0, 0);
        add(1, 0, 0, SEL_IR,   0, 0, 0, 0);
        add(0, 0, 0, CAP_IR,   0, 0, 0, 0);
        add(0, 0, 0, SH_IR,    0, 0, 0, 0);
        add(0, 0, 0, SH_IR,    0, 0, 0, 1);
        add(0, 1, 0, SH_IR,    0, 0, 0, 0);
        add(1, 0, 0, EX1_IR,   0, 0, 0, 0);
        add(1, 0, 0, UPD_IR,   0, 0, 0, 0);
        add(0, 0, 0, RTI,      2, 0, 1, 0);
        add(0, 0, 0, RTI,      2, 0, 0, 0);
        // load SAMPLE (001), then a DR scan through bsr_tdo
        add(1, 0, 0, SEL_DR,   2, 0, 0, 0);
        add(1, 0, 0, SEL_IR,   2, 0, 0, 0);
        add(0, 0, 0, CAP_IR,   2, 0, 0, 0);
        add(0, 0, 0, SH_IR,    2, 0, 0, 0);
        add(0, 1, 0, SH_IR,    2, 0, 0, 1);
        add(0, 0, 0, SH_IR,    2, 0, 0, 0);
        add(1, 0, 0, EX1_IR,   2, 0, 0, 0);
        add(1, 0, 0, UPD_IR,   2, 0, 0, 0);
        add(0, 0, 0, RTI,      1, 0, 0, 0);
        add(1, 0, 0, SEL_DR,   1, 0, 0, 0);
        add(0, 0, 0, CAP_DR,   1, 0, 0, 0);
        add(0, 0, 1, SH_DR,    1, 0, 0, 0);
        add(0, 0, 1, SH_DR,    1, 0, 0, 1);
        add(1, 0, 0, EX1_DR,   1, 0, 0, 0);
        add(1, 0, 0, UPD_DR,   1, 0, 0, 0);
        add(0, 0, 0, RTI,      1, 0, 0, 0);
        // load BYPASS (111)
        add(1, 0, 0, SEL_DR,   1, 0, 0, 0);
        add(1, 0, 0, SEL_IR,   1, 0, 0, 0);
        add(0, 0, 0, CAP_IR,   1, 0, 0, 0);
        add(0, 0, 0, SH_IR,    1, 0, 0, 0);
        add(0, 1, 0, SH_IR,    1, 0, 0, 1);
        add(0, 1, 0, SH_IR,    1, 0, 0, 0);
        add(1, 1, 0, EX1_IR,   1, 0, 0, 0);
        add(1, 0, 0, UPD_IR,   1, 0, 0, 0);
        add(0, 0, 0, RTI,      7, 0, 0, 0);
        // bypass DR scan 1,0,1,1 with a pause in the middle
        add(1, 0, 1, SEL_DR,   7, 0, 0, 0);
        add(0, 0, 1, CAP_DR,   7, 0, 0, 0);
        add(0, 0, 1, SH_DR,    7, 0, 0, 0);
        add(0, 1, 1, SH_DR,    7, 0, 0, 0);
        add(0, 0, 1, SH_DR,    7, 0, 0, 1);
        add(0, 1, 1, SH_DR,    7, 0, 0, 0);
        add(0, 1, 1, SH_DR,    7, 0, 0, 1);
        add(1, 0, 1, EX1_DR,   7, 0, 0, 1);
        add(0, 1, 1, PAUSE_DR, 7, 0, 0, 1);
        add(0, 1, 1, PAUSE_DR, 7, 0, 0, 1);
        add(1, 1, 1, EX2_DR,   7, 0, 0, 1);
        add(0, 1, 1, SH_DR,    7, 0, 0, 1);
        add(1, 1, 1, EX1_DR,   7, 0, 0, 0);
        add(1, 0, 0, UPD_DR,   7, 0, 0, 0);
        add(0, 0, 0, RTI,      7, 0, 0, 0);
        // load undefined 101, then five tms=1 from ShDR
        add(1, 0, 0, SEL_DR,   7, 0, 0, 0);
        add(1, 0, 0, SEL_IR,   7, 0, 0, 0);
        add(0, 0, 0, CAP_IR,   7, 0, 0, 0);
        add(0, 0, 0, SH_IR,    7, 0, 0, 0);
        add(0, 1, 0, SH_IR,    7, 0, 0, 1);
        add(0, 0, 0, SH_IR,    7, 0, 0, 0);
        add(1, 1, 0, EX1_IR,   7, 0, 0, 0);
        add(1, 0, 0, UPD_IR,   7, 0, 0, 0);
        add(0, 0, 0, RTI,      5, 0, 0, 0);
        add(1, 0, 0, SEL_DR,   5, 0, 0, 0);
        add(0, 0, 0, CAP_DR,   5, 0, 0, 0);
        add(0, 0, 0, SH_DR,    5, 0, 0, 0);
        add(1, 1, 0, EX1_DR,   5, 0, 0, 0);
        add(1, 0, 0, UPD_DR,   5, 0, 0, 0);
        add(1, 0, 0, SEL_DR,   5, 0, 0, 0);
        add(1, 0, 0, SEL_IR,   5, 0, 0, 0);
        add(1, 0, 0, TLR,      7, 0, 0, 0);
        add(1, 0, 0, TLR,      7, 0, 0, 0);
        add(0, 0, 0, RTI,      7, 0, 0, 0);

        // asynchronous reset, checked before any clock edge
        rst     = 1'b1;
        tms     = 1'b1;
        tdi     = 1'b0;
        bsr_tdo = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_state",  0, 8'(tap_state), 8'(TLR));
        chk("rst_ir_q",   0, 8'(ir_q), 8'h7);
        chk("rst_tdo",    0, 8'(tdo), 8'h0);
        chk("rst_extest", 0, 8'(extest), 8'h0);
        chk("rst_intest", 0, 8'(intest), 8'h0);
        chk("rst_bsel",   0, 8'(bypass_sel), 8'h1);
        chk("rst_cap",    0, 8'(capture_dr), 8'h0);
        chk("rst_shift",  0, 8'(shift_dr), 8'h0);
        chk("rst_upd",    0, 8'(update_dr), 8'h0);
        @(negedge clk);
        tms = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_state", 0, 8'(tap_state), 8'(TLR));
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            tms     = vecs[i].tms;
            tdi     = vecs[i].tdi;
            bsr_tdo = vecs[i].bsr;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            chk("state",      i + 1, 8'(tap_state), 8'(e.st));
            chk("ir_q",       i + 1, 8'(ir_q), 8'(e.ir));
            chk("extest",     i + 1, 8'(extest), 8'(e.ex));
            chk("intest",     i + 1, 8'(intest), 8'(e.ins));
            chk("tdo",        i + 1, 8'(tdo), 8'(e.tdo));
            chk("bypass_sel", i + 1, 8'(bypass_sel), 8'(exp_bsel(e.ir)));
            chk("capture_dr", i + 1, 8'(capture_dr), 8'(e.st == CAP_DR));
            chk("shift_dr",   i + 1, 8'(shift_dr), 8'(e.st == SH_DR));
            chk("update_dr",  i + 1, 8'(update_dr), 8'(e.st == UPD_DR));
        end

        // reset in ShIR after two shifts of an EXTEST load
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("pre_rst_state", 200, 8'(tap_state), 8'(SH_IR));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_state",  200, 8'(tap_state), 8'(TLR));
        chk("mid_rst_ir_q",   200, 8'(ir_q), 8'h7);
        chk("mid_rst_tdo",    200, 8'(tdo), 8'h0);
        chk("mid_rst_extest", 200, 8'(extest), 8'h0);
        chk("mid_rst_shift",  200, 8'(shift_dr), 8'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0);
            chk("post_rst_state",  201 + k, 8'(tap_state), 8'(RTI));
            chk("post_rst_ir_q",   201 + k, 8'(ir_q), 8'h7);
            chk("post_rst_extest", 201 + k, 8'(extest), 8'h0);
            chk("post_rst_intest", 201 + k, 8'(intest), 8'h0);
        end

        // five tms=1 reach TLR from wherever a random walk ends
        for (int k = 0; k < 12; k++) begin
            int n;
            n = int'($urandom_range(0, 12));
            for (int j = 0; j < n; j++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int j = 0; j < 5; j++) step(1'b1, 1'b0);
            chk("walk_tlr_state", 300 + k, 8'(tap_state), 8'(TLR));
            chk("walk_tlr_ir_q",  300 + k, 8'(ir_q), 8'h7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ir.md
JTAG_TAP_IR -- requirements
Module: jtag_tap_ir

Interface
REQ-001 The block SHALL have parameter IR_W, default 3, giving the instruction register width.
REQ-002 The block SHALL have port clk, input, 1 bit: test clock (TCK); all state changes on posedge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset; clock is clk.
REQ-004 The block SHALL have port tms, input, 1 bit: test mode select, sampled on posedge clk.
REQ-005 The block SHALL have port tdi, input, 1 bit: serial test data in.
REQ-006 The block SHALL have port bsr_tdo, input, 1 bit: serial return from the boundary-scan cell chain.
REQ-007 The block SHALL have port tdo, output, 1 bit: registered serial test data out.
REQ-008 The block SHALL have port ir_q, output, IR_W bits: active instruction.
REQ-009 The block SHALL have ports extest and intest, output, 1 bit each: one-cycle start pulses to the downstream scan sequencer.
REQ-010 The block SHALL have port bypass_sel, output, 1 bit: level, high while ir_q decodes to BYPASS.
REQ-011 The block SHALL have ports capture_dr, shift_dr and update_dr, output, 1 bit each: high while the TAP is in the corresponding DR state.
REQ-012 The block SHALL have port tap_state, output, 4 bits: current TAP state encoding.

Function
REQ-013 The block SHALL implement the 16-state IEEE 1149.1 TAP FSM with the standard TMS transitions: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
REQ-014 Five consecutive posedges with tms=1 SHALL reach TLR from any state.
REQ-015 Instruction codes SHALL be EXTEST=000, SAMPLE=001, INTEST=010, BYPASS=111.
REQ-016 Any undefined instruction code SHALL decode as BYPASS.
REQ-017 In CapIR, the IR shift register SHALL load {IR_W-2 zeros, 2'b01}.
REQ-018 In ShIR, the IR shift register SHALL shift right one bit per clk, with tdi entering the MSB.
REQ-019 In UpdIR, ir_q SHALL load the IR shift register; ir_q SHALL NOT change in any other state except TLR.
REQ-020 While in TLR, ir_q SHALL be forced to BYPASS.
REQ-021 extest (intest) SHALL pulse high for exactly one clk in the cycle after UpdIR when the newly loaded ir_q is EXTEST (INTEST).
REQ-022 extest and intest SHALL never be high simultaneously and SHALL NOT pulse on a reload of SAMPLE or BYPASS.
REQ-023 The 1-bit bypass register SHALL load 0 in CapDR and load tdi in ShDR.
REQ-024 tdo SHALL be registered on posedge clk with this source: the IR shift LSB in ShIR; the bypass bit in ShDR with bypass_sel=1; bsr_tdo in ShDR with bypass_sel=0.
REQ-025 tdo SHALL hold its last value in all other states.
REQ-026 capture_dr, shift_dr and update_dr SHALL be Moore decodes of the state register, with zero added latency.
REQ-027 update_dr SHALL be high for exactly one clk per DR scan.
REQ-028 Pause states SHALL freeze all shift registers and tdo.

Reset
REQ-029 When rst=0, the block SHALL immediately and asynchronously set: state=TLR, ir_q=BYPASS, IR shift=BYPASS, bypass bit=0, tdo=0, and extest=intest=0.
REQ-030 When rst=0, capture_dr, shift_dr and update_dr SHALL be 0.
REQ-031 Reset asserted mid-scan SHALL abandon the scan with no update and no start pulse.
REQ-032 The first tms sample after rst deasserts SHALL be taken at the next posedge.

Structure
REQ-033 A shared package jtag_pkg SHALL hold the TAP state enum with 4-bit encodings, the instruction code constants, and IR_W.
REQ-034 The TAP FSM SHALL be the sub-module jtag_tap_fsm, with inputs clk, rst, tms and output state.
REQ-035 IR, bypass and tdo logic SHALL reside in jtag_tap_ir.

Verification
REQ-036 Reset, then drive tms=0: state SHALL go TLR->RTI, with ir_q=111 and bypass_sel=1.
REQ-037 From RTI, scan IR 000 via tms sequence 1,1,0,0,(shift 3),1,1,0; then tdo SHALL shift out 1,0,0, and extest SHALL pulse once the cycle after UpdIR, with ir_q=000.
REQ-038 Load IR 010: intest SHALL pulse once, and extest SHALL stay 0.
REQ-039 With BYPASS active, shift DR with tdi pattern 1,0,1,1: tdo SHALL present 0,1,0,1,1, i.e. one-cycle delay after the captured 0.
REQ-040 Load IR 101 (undefined): bypass_sel SHALL be 1 and no pulse SHALL occur; five tms=1 cycles from ShDR SHALL reach TLR with ir_q=111.
REQ-041 Assert rst during ShIR after 2 shifts: ir_q SHALL stay 111, no pulse SHALL occur, and state SHALL be TLR immediately.
